// File: rtl/sub_bytes_serial.sv
// AES SubBytes over a 128-bit state, LANES bytes per clock through LANES S-boxes.
// Accept in IDLE, substitute in place over N RUN cycles, then hold the result in DONE.
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  localparam int N  = 16 / LANES;
  localparam int W  = 8 * LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Valid/ready: a transfer happens on a rising clk_i edge where valid and ready are both
  // high; valid never depends on ready, and a raised out_valid_o holds with stable data.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   buf_q, buf_d;
  logic [W-1:0]   chunk_in, chunk_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    b = gf_mul(r, r);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    chunk_in = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) chunk_in = buf_q[k*W +: W];
    end
  end

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign chunk_out[8*j +: 8] = sbox(chunk_in[8*j +: 8]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            buf_d   = in_data_i;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) buf_d[k*W +: W] = chunk_out;
          end
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = buf_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial: LANES=4, 1 and 16 instances run in lockstep on shared inputs,
// checked against hand-computed vectors and a table-based S-box model.
module tb_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_data [3];

  always #5 clk = ~clk;

  sub_bytes_serial #(.LANES(4)) dut_l4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_data_i(in_data), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .out_data_o(out_data[0]), .busy_o(busy[0]));
  sub_bytes_serial #(.LANES(1)) dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_data_i(in_data), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .out_data_o(out_data[1]), .busy_o(busy[1]));
  sub_bytes_serial #(.LANES(16)) dut_l16 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .in_data_i(in_data), .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .out_data_o(out_data[2]), .busy_o(busy[2]));

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  string        lname[3]   = '{"L4", "L1", "L16"};
  int           lat_exp[3] = '{4, 16, 1};

  // FIPS-197 S-box, row-major, entry 0 in the top byte.
  logic [2047:0] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_bits[2047 - 8*int'(d[8*i +: 8]) -: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic do_accept(input logic [127:0] d, input logic [127:0] e);
    in_valid = 1'b1;
    in_data  = d;
    tick;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("accept busy", 128'(busy), 128'(3'b111));
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input bit chk_lat);
    int   t = 0;
    int   lat[3] = '{0, 0, 0};
    logic rdy_seen = 1'b0;
    while (out_valid != 3'b111 && t < 40) begin
      tick;
      t++;
      for (int d = 0; d < 3; d++) if (out_valid[d] && lat[d] == 0) lat[d] = t;
      if (|in_ready) rdy_seen = 1'b1;
    end
    if (out_valid != 3'b111) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout out_valid: got %b required 111", out_valid);
    end
    if (chk_lat) begin
      for (int d = 0; d < 3; d++) check({"latency ", lname[d]}, 128'(lat[d]), 128'(lat_exp[d]));
      check("in_ready low while busy", 128'(rdy_seen), 128'(0));
    end
  endtask

  task automatic drain(input int stall);
    logic [127:0] snap[3];
    logic [127:0] e;
    logic         bad = 1'b0;
    for (int d = 0; d < 3; d++) snap[d] = out_data[d];
    repeat (stall) begin
      tick;
      if (out_valid != 3'b111 || in_ready != 3'b000) bad = 1'b1;
      for (int d = 0; d < 3; d++) if (out_data[d] !== snap[d]) bad = 1'b1;
    end
    if (stall > 0) check("hold stable under stall", 128'(bad), 128'(0));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int d = 0; d < 3; d++) check({"data ", lname[d]}, out_data[d], e);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("idle after handshake", 128'({out_valid, in_ready, busy}), 128'({3'b000, 3'b111, 3'b000}));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic         seen;

    vecs[0] = '{din: {16{8'h00}}, dout: {16{8'h63}}};
    vecs[1] = '{din: {16{8'h53}}, dout: {16{8'hed}}};
    vecs[2] = '{din: {16{8'hff}}, dout: {16{8'h16}}};
    vecs[3] = '{din: {16{8'h01}}, dout: {16{8'h7c}}};
    vecs[4] = '{din: 128'h0848f8e92a8dc69a2be2f4a0bee33d19,
                dout: 128'h3052411ee55db4b8f198bfe0ae1127d4};

    do_reset;
    check("reset in_ready", 128'(in_ready), 128'(3'b111));
    check("reset out_valid", 128'(out_valid), 128'(3'b000));
    check("reset busy", 128'(busy), 128'(3'b000));
    for (int k = 0; k < 3; k++) check({"reset data ", lname[k]}, out_data[k], 128'h0);

    // Directed vectors; latency checked on every one.
    for (int v = 0; v < 5; v++) begin
      do_accept(vecs[v].din, vecs[v].dout);
      wait_valid(1'b1);
      drain(v);
    end

    // Every byte value once.
    for (int s = 0; s < 16; s++) begin
      for (int b = 0; b < 16; b++) d[8*b +: 8] = 8'(s * 16 + b);
      do_accept(d, model(d));
      wait_valid(1'b1);
      drain(0);
    end

    // Backpressure with a new state waiting on in_valid the whole time.
    do_accept({16{8'h00}}, {16{8'h63}});
    in_valid = 1'b1;
    in_data  = {16{8'hff}};
    wait_valid(1'b0);
    drain(10);
    exp_q.push_back({16{8'h16}});
    tick;
    in_valid = 1'b0;
    check("waiting state accepted after idle", 128'(busy), 128'(3'b111));
    wait_valid(1'b1);
    drain(1);

    // Flush during the second RUN cycle of the LANES=4 instance.
    do_accept(vecs[4].din, vecs[4].dout);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush to idle", 128'({out_valid, in_ready, busy}), 128'({3'b000, 3'b111, 3'b000}));
    seen = 1'b0;
    repeat (5) begin
      tick;
      if (|out_valid || |busy) seen = 1'b1;
    end
    check("no output after flush", 128'(seen), 128'(0));

    // A valid input coinciding with flush is dropped.
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = vecs[1].din;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush blocks accept", 128'(busy), 128'(3'b000));

    // Async reset while results are held in DONE.
    do_accept(vecs[3].din, vecs[3].dout);
    wait_valid(1'b0);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("reset in DONE flags", 128'({out_valid, in_ready, busy}), 128'({3'b000, 3'b111, 3'b000}));
    check("reset in DONE data", out_data[0], 128'h0);
    tick;
    rst_n = 1'b1;
    tick;
    do_accept(vecs[4].din, vecs[4].dout);
    wait_valid(1'b1);
    drain(2);

    // Random states with idle gaps and output stalls.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) tick;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_accept(d, model(d));
      wait_valid(1'b0);
      drain($urandom_range(0, 3));
    end

    check("scoreboard empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
